mega_jsoc_sysinfo: RTL and testbench



---
 rtl/mega_jsoc_sysinfo_pkg.sv | 37 +++
 rtl/mega_jsoc_sysinfo_rdpipe.sv | 47 ++++
 rtl/mega_jsoc_sysinfo.sv | 136 +++++++++++++
 tb/tb_mega_jsoc_sysinfo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mega_jsoc_sysinfo_pkg.sv
// Shared constants for the JSoC system-info slave: register map, control/status
// bit positions and the legal read-latency window.
package mega_jsoc_sysinfo_pkg;

    localparam logic [2:0] ADDR_SYSID   = 3'd0;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] ADDR_CYCLO   = 3'd2;
    localparam logic [2:0] ADDR_CYCHI   = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;
    localparam logic [2:0] ADDR_CAPS    = 3'd7;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;
    localparam int CTRL_IE_BIT    = 2;
    localparam int STATUS_OVF_BIT = 0;

    localparam int RDLAT_MIN = 1;
    localparam int RDLAT_MAX = 4;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mega_jsoc_sysinfo_rdpipe.sv
// Fixed-depth valid/data shift pipeline for read responses; data lanes are
// zero whenever their valid bit is low.
module mega_jsoc_sysinfo_rdpipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [WIDTH-1:0]   data_d [LATENCY];

    // Next-stage values: shift one step, masking data of empty slots.
    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_valid ? in_data : {WIDTH{1'b0}};
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Pipeline registers; reset drops every in-flight response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mega_jsoc_sysinfo.sv
// JSoC system-info Avalon-MM slave: ID/timestamp words, free-running cycle
// counter with atomic hi/lo snapshot, scratch, control/status and overflow irq.
module mega_jsoc_sysinfo
    import mega_jsoc_sysinfo_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID      = 32'h0000_001D,
    parameter logic [31:0] TIMESTAMP      = 32'd1718298719,
    parameter int          CNT_WIDTH      = 64,
    parameter int          READ_LATENCY   = 1,
    parameter logic [31:0] SCRATCH_RESET  = 32'h0000_0000,
    parameter logic        COUNT_EN_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          shadow_hi_q, shadow_hi_d;
    logic [31:0]          scratch_q, scratch_d;
    logic                 en_q, en_d;
    logic                 ie_q, ie_d;
    logic                 ovf_q, ovf_d;
    logic                 irq_q, irq_d;

    logic [63:0] cnt_ext;
    logic [31:0] rd_word;
    logic        rd_accept, wr_ctrl, wr_status, wr_scratch, clr, wrap;

    assign cnt_ext    = 64'(cnt_q);
    assign rd_accept  = read & ~write;
    assign wr_ctrl    = write & (address == ADDR_CTRL);
    assign wr_status  = write & (address == ADDR_STATUS);
    assign wr_scratch = write & (address == ADDR_SCRATCH);
    assign clr        = wr_ctrl & writedata[CTRL_CLR_BIT];
    assign wrap       = en_q & ~clr & (&cnt_q);

    // Register next-state: clear beats increment, overflow set beats W1C.
    always_comb begin
        if (clr) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (en_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (rd_accept && (address == ADDR_CYCLO)) begin
            shadow_hi_d = cnt_ext[63:32];
        end else begin
            shadow_hi_d = shadow_hi_q;
        end

        if (wr_scratch) begin
            scratch_d = be_merge(scratch_q, writedata, byteenable);
        end else begin
            scratch_d = scratch_q;
        end

        if (wr_ctrl) begin
            en_d = writedata[CTRL_EN_BIT];
            ie_d = writedata[CTRL_IE_BIT];
        end else begin
            en_d = en_q;
            ie_d = ie_q;
        end

        if (wrap) begin
            ovf_d = 1'b1;
        end else if (wr_status && writedata[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        irq_d = ovf_d & ie_d;
    end

    // Read mux sees pre-edge state, so a same-cycle write is never visible.
    always_comb begin
        case (address)
            ADDR_SYSID:   rd_word = SYSTEM_ID;
            ADDR_TSTAMP:  rd_word = TIMESTAMP;
            ADDR_CYCLO:   rd_word = cnt_ext[31:0];
            ADDR_CYCHI:   rd_word = shadow_hi_q;
            ADDR_SCRATCH: rd_word = scratch_q;
            ADDR_CTRL:    rd_word = {29'd0, ie_q, 1'b0, en_q};
            ADDR_STATUS:  rd_word = {31'd0, ovf_q};
            ADDR_CAPS:    rd_word = {21'd0, 3'(READ_LATENCY), 8'(CNT_WIDTH)};
            default:      rd_word = 32'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= {CNT_WIDTH{1'b0}};
            shadow_hi_q <= 32'd0;
            scratch_q   <= SCRATCH_RESET;
            en_q        <= COUNT_EN_RESET;
            ie_q        <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shadow_hi_q <= shadow_hi_d;
            scratch_q   <= scratch_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
        end
    end

    assign irq = irq_q;

    mega_jsoc_sysinfo_rdpipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (32)
    ) u_rdpipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .out_valid (readdatavalid),
        .out_data  (readdata)
    );

endmodule

// File: tb/tb_mega_jsoc_sysinfo.sv
// Scoreboard bench for two sysinfo instances: A (64-bit counter, latency 3)
// and B (33-bit counter, latency 1, non-zero scratch reset).
module tb_mega_jsoc_sysinfo;
    import mega_jsoc_sysinfo_pkg::*;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;
    localparam logic [31:0] SCR_RST_B = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd [2];
    logic        wr [2];
    logic [2:0]  addr [2];
    logic [31:0] wdat [2];
    logic [3:0]  be [2];
    logic [31:0] rdata [2];
    logic        rvalid [2];
    logic        irq [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses [2];

    typedef struct {
        logic [31:0] data;
        int          due;
        int          u;
        string       name;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mega_jsoc_sysinfo #(
        .CNT_WIDTH(64), .READ_LATENCY(LAT_A)
    ) dut_a (
        .clock(clk), .reset_n(rst_n), .address(addr[0]), .read(rd[0]),
        .write(wr[0]), .writedata(wdat[0]), .byteenable(be[0]),
        .readdata(rdata[0]), .readdatavalid(rvalid[0]), .irq(irq[0])
    );

    mega_jsoc_sysinfo #(
        .CNT_WIDTH(33), .READ_LATENCY(LAT_B), .SCRATCH_RESET(SCR_RST_B)
    ) dut_b (
        .clock(clk), .reset_n(rst_n), .address(addr[1]), .read(rd[1]),
        .write(wr[1]), .writedata(wdat[1]), .byteenable(be[1]),
        .readdata(rdata[1]), .readdatavalid(rvalid[1]), .irq(irq[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    // Monitor: match each response against the oldest expectation for that DUT.
    task automatic mon_one(input int u);
        int idx[$];
        exp_t e;
        idx = sb.find_first_index(x) with (x.u == u);
        if (rvalid[u]) begin
            pulses[u]++;
            if (idx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid dut%0d: got readdatavalid=1 data=%h, required none", u, rdata[u]);
            end else begin
                e = sb[idx[0]];
                sb.delete(idx[0]);
                check(e.name, rdata[u], e.data);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end else begin
            check("rdata_zero_idle", rdata[u], 32'h0);
            if (idx.size() != 0 && sb[idx[0]].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_valid %s: got no response by cycle %0d, required at %0d",
                         sb[idx[0]].name, cyc, sb[idx[0]].due);
                sb.delete(idx[0]);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon_one(u);
    end

    task automatic all_idle();
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 3'd0; wdat[i] = 32'd0; be[i] = 4'h0;
        end
    endtask

    // One bus cycle; called just after a falling edge, returns at the next one.
    task automatic op(input int u, input logic r, input logic w, input logic [2:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      input logic [31:0] e, input string nm);
        all_idle();
        rd[u] = r; wr[u] = w; addr[u] = a; wdat[u] = d; be[u] = b;
        if (r && !w) sb.push_back('{e, cyc + ((u == 0) ? LAT_A : LAT_B), u, nm});
        @(negedge clk);
        all_idle();
    endtask

    task automatic rd_op(input int u, input logic [2:0] a, input logic [31:0] e, input string nm);
        op(u, 1'b1, 1'b0, a, 32'd0, 4'h0, e, nm);
    endtask

    task automatic wr_op(input int u, input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        op(u, 1'b0, 1'b1, a, d, b, 32'd0, "");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        pulses[0] = 0;
        pulses[1] = 0;
        all_idle();
        idle(3);
        check("rst_irq_a", {31'd0, irq[0]}, 32'd0);
        check("rst_irq_b", {31'd0, irq[1]}, 32'd0);
        check("rst_valid_a", {31'd0, rvalid[0]}, 32'd0);
        rst_n = 1'b1;

        // Back-to-back reads of constant words, latency 3.
        rd_op(0, ADDR_SYSID,  32'h0000_001D, "sysid");
        rd_op(0, ADDR_TSTAMP, 32'd1718298719, "timestamp");
        rd_op(0, ADDR_CAPS,   32'h0000_0340, "caps_a");
        rd_op(1, ADDR_CAPS,   32'h0000_0121, "caps_b");

        // Byte-enabled scratch writes.
        wr_op(0, ADDR_SCRATCH, 32'hAABB_CCDD, 4'hF);
        wr_op(0, ADDR_SCRATCH, 32'h0000_1100, 4'b0010);
        rd_op(0, ADDR_SCRATCH, 32'hAABB_11DD, "scratch_be");

        // Read+write together: write lands, read dropped.
        op(0, 1'b1, 1'b1, ADDR_SCRATCH, 32'h1234_5678, 4'hF, 32'd0, "");
        rd_op(0, ADDR_SCRATCH, 32'h1234_5678, "scratch_rw");
        idle(4);

        // Snapshot: LO read latches HI; HI read later returns the snapshot.
        force dut_a.cnt_q = 64'h0000_0001_FFFF_FFFF;
        #1 release dut_a.cnt_q;
        rd_op(0, ADDR_CYCLO, 32'hFFFF_FFFF, "cyc_lo_snap");
        idle(4);
        rd_op(0, ADDR_CYCHI, 32'h0000_0001, "cyc_hi_snap");

        // CLR with EN (byteenable ignored on CTRL).
        wr_op(0, ADDR_CTRL, 32'h0000_0003, 4'h0);
        rd_op(0, ADDR_CYCLO, 32'd0, "cyc_after_clr");
        rd_op(0, ADDR_CTRL,  32'h0000_0001, "ctrl_readback");
        rd_op(0, ADDR_CYCLO, 32'd2, "cyc_counting");

        // 33-bit wrap with W1C in the wrap cycle: set wins.
        wr_op(1, ADDR_CTRL, 32'h0000_0005, 4'hF);
        force dut_b.cnt_q = 33'h1_FFFF_FFFD;
        #1 release dut_b.cnt_q;
        op(1, 1'b0, 1'b0, ADDR_SYSID, 32'd0, 4'h0, 32'd0, "");
        check("irq_before_wrap1", {31'd0, irq[1]}, 32'd0);
        op(1, 1'b0, 1'b0, ADDR_SYSID, 32'd0, 4'h0, 32'd0, "");
        check("irq_before_wrap2", {31'd0, irq[1]}, 32'd0);
        wr_op(1, ADDR_STATUS, 32'h0000_0001, 4'hF);
        check("irq_on_wrap", {31'd0, irq[1]}, 32'd1);
        rd_op(1, ADDR_STATUS, 32'd1, "ovf_set_wins");
        rd_op(1, ADDR_CYCLO, 32'd1, "cyc_after_wrap");
        wr_op(1, ADDR_STATUS, 32'h0000_0001, 4'h0);
        check("irq_after_w1c", {31'd0, irq[1]}, 32'd0);
        rd_op(1, ADDR_STATUS, 32'd0, "ovf_cleared");
        idle(5);

        // Reset with two reads in flight: neither may complete.
        p0 = pulses[0];
        all_idle();
        rd[0] = 1'b1; addr[0] = ADDR_SYSID;
        @(negedge clk);
        @(negedge clk);
        all_idle();
        rst_n = 1'b0;
        idle(5);
        check("flush_no_valid", 32'(pulses[0]), 32'(p0));
        rst_n = 1'b1;

        rd_op(0, ADDR_CYCLO,   32'd0, "cnt_rst");
        rd_op(0, ADDR_CYCHI,   32'd0, "shadow_rst");
        rd_op(0, ADDR_SCRATCH, 32'd0, "scratch_rst_a");
        rd_op(0, ADDR_CTRL,    32'h0000_0001, "ctrl_rst_a");
        rd_op(1, ADDR_SCRATCH, SCR_RST_B, "scratch_rst_b");
        rd_op(1, ADDR_STATUS,  32'd0, "status_rst_b");
        rd_op(1, ADDR_CTRL,    32'h0000_0001, "ctrl_rst_b");
        idle(6);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
